// File: rtl/neuron_mac.sv
// neuron_mac: layer-2 neuron datapath.
// Streams one activation vector per neuron evaluation. The weight memory is
// addressed in lockstep with the incoming activations. Each vector is
// multiply-accumulated, biased, rescaled, saturated and passed through the
// activation function, producing one result per vector.
module neuron_mac #(
  parameter int numWeight    = 30,
  parameter int addressWidth = $clog2(numWeight),
  parameter int dataWidth    = 16,
  parameter int fracBits     = 8,
  parameter int actType      = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           x_valid,
  input  logic signed [dataWidth-1:0]    x_in,
  input  logic signed [dataWidth-1:0]    bias,
  output logic                           w_ren,
  output logic        [addressWidth-1:0] w_radd,
  input  logic signed [dataWidth-1:0]    w_data,
  output logic                           out_valid,
  output logic signed [dataWidth-1:0]    out_data,
  output logic                           busy
);

  // The accumulator is wide enough that summing numWeight full-scale products cannot overflow
  localparam int accWidth  = 2 * dataWidth + $clog2(numWeight);
  localparam int prodWidth = 2 * dataWidth;

  localparam logic [addressWidth-1:0] lastIdx = addressWidth'(numWeight - 1);

  // Clamp limits of the result format, widened to the post-shift sum width
  localparam logic signed [accWidth:0] satMax =
    {{(accWidth + 2 - dataWidth){1'b0}}, {(dataWidth - 1){1'b1}}};
  localparam logic signed [accWidth:0] satMin =
    {{(accWidth + 2 - dataWidth){1'b1}}, {(dataWidth - 1){1'b0}}};

  // Stage 0 registers: element index plus the activation held for the weight read latency
  logic        [addressWidth-1:0] idx_q;
  logic signed [dataWidth-1:0]    x_q;
  logic                           v_q;
  logic                           first_q;
  logic                           last_q;

  // Stage 1 registers: running sum and the "vector complete" marker
  logic signed [accWidth-1:0]     acc_q, acc_d;
  logic                           fin_q;

  // Stage 2 registers: final result
  logic                           outValid_q;
  logic signed [dataWidth-1:0]    outData_q, outData_d;

  logic signed [prodWidth-1:0]    prod;
  logic signed [accWidth:0]       biasScaled;
  logic signed [accWidth:0]       sum;
  logic signed [accWidth:0]       shifted;

  logic                           accept;

  // A flush in the same cycle as x_valid wins, so the sample is neither read nor counted
  assign accept = x_valid & ~flush;
  assign w_ren  = accept;
  assign w_radd = idx_q;

  assign busy      = (idx_q != '0) | v_q | fin_q;
  assign out_valid = outValid_q;
  assign out_data  = outData_q;

  // Stage 0: count elements and hold each activation until its weight returns from memory
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      x_q     <= '0;
      v_q     <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (flush) begin
      idx_q <= '0;
      v_q   <= 1'b0;
    end else if (x_valid) begin
      x_q     <= x_in;
      v_q     <= 1'b1;
      first_q <= (idx_q == '0);
      last_q  <= (idx_q == lastIdx);
      idx_q   <= (idx_q == lastIdx) ? '0 : idx_q + addressWidth'(1);
    end else begin
      v_q <= 1'b0;
    end
  end

  // Product and accumulator next value; the first element restarts the sum so back-to-back vectors need no clear cycle
  always_comb begin
    acc_d = acc_q;
    prod  = x_q * w_data;
    if (v_q) begin
      if (first_q) begin
        acc_d = {{(accWidth - prodWidth){prod[prodWidth-1]}}, prod};
      end else begin
        acc_d = acc_q + {{(accWidth - prodWidth){prod[prodWidth-1]}}, prod};
      end
    end
  end

  // Stage 1: register the running sum and flag when the last element has been folded in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      fin_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      fin_q <= flush ? 1'b0 : (v_q & last_q);
    end
  end

  // Bias alignment, rescale to the result format, saturation and activation
  always_comb begin
    biasScaled = {{(accWidth + 1 - dataWidth - fracBits){bias[dataWidth-1]}},
                  bias, {fracBits{1'b0}}};
    sum        = {acc_q[accWidth-1], acc_q} + biasScaled;
    shifted    = sum >>> fracBits;
    if (shifted > satMax) begin
      outData_d = {1'b0, {(dataWidth - 1){1'b1}}};
    end else if (shifted < satMin) begin
      outData_d = {1'b1, {(dataWidth - 1){1'b0}}};
    end else begin
      outData_d = shifted[dataWidth-1:0];
    end
    if (actType == 0 && outData_d[dataWidth-1]) begin
      outData_d = '0;
    end
  end

  // Stage 2: capture the result on the cycle after the completed sum lands; stage 1 may already be overwriting it for the next vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q <= 1'b0;
      outData_q  <= '0;
    end else if (fin_q && !flush) begin
      outValid_q <= 1'b1;
      outData_q  <= outData_d;
    end else begin
      outValid_q <= 1'b0;
    end
  end

endmodule
